inc16_serial_ctrl: RTL and testbench

//  Nibble-serial sequencer for the 16-bit incrementer datapath.
//  - Time-shares one internal NIB_W-bit half-adder ripple slice (HA chain, carry-in = prior carry) over

---
 rtl/inc16_serial_ctrl.sv | 164 ++++++++++++++++
 tb/tb_inc16_serial_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inc16_serial_ctrl.sv
// ---------------------------------------------------------------------------
// inc16_serial_ctrl
//
// Nibble-serial incrementer. Computes dout = din + 1 (mod 2^DATA_W) by reusing
// one NIB_W-bit half-adder ripple slice over DATA_W/NIB_W cycles. The ripple
// carry between nibbles is kept in a register. This trades latency for a much
// shorter adder. The block uses a start/ready/done handshake.
//
// Optional build macro:
//   INC_EARLY_EXIT_EN - leave RUN as soon as a slice produces no carry-out.
//                       The remaining upper nibbles already equal the operand.
//                       The results are identical in both builds; only the
//                       timing differs.
//
// Ports:
//   clk_i    in   1       clock, every state update happens on the rising edge
//   rst_i    in   1       synchronous active-high reset
//   start_i  in   1       request, sampled only while ready_o = 1
//   din_i    in   DATA_W  operand, captured on the accepting edge
//   ready_o  out  1       high only in IDLE
//   busy_o   out  1       high while nibbles are being processed (RUN)
//   done_o   out  1       one-cycle pulse; dout_o/cout_o valid from this cycle
//   dout_o   out  DATA_W  din + 1, held until the next done
//   cout_o   out  1       final carry, 1 iff the operand was all ones
// ---------------------------------------------------------------------------
module inc16_serial_ctrl #(
   parameter int DATA_W = 16,
   parameter int NIB_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] din_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] dout_o,
   output logic              cout_o
);

   localparam int STEPS = DATA_W / NIB_W;
   localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   work_q, work_d;
   logic                carry_q, carry_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                cout_q, cout_d;

   logic [NIB_W-1:0]    sliceIn;
   logic [NIB_W-1:0]    sliceSum;
   logic                sliceCout;
   logic                rippleC;
   logic [DATA_W-1:0]   workUpd;
   logic                lastStep;
   logic                finish;

   // State register. Reset discards any partial result and clears the outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         work_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         dout_q  <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         cout_q  <= cout_d;
      end
   end

   // The shared slice is a half-adder ripple with no B operand. The stored
   // carry enters at the LSB. That carry is 1 for the first nibble, which
   // supplies the "+1".
   always_comb begin
      sliceIn = work_q[32'(idx_q)*NIB_W +: NIB_W];
      rippleC = carry_q;
      sliceSum = '0;
      for (int i = 0; i < NIB_W; i++) begin
         sliceSum[i] = sliceIn[i] ^ rippleC;
         rippleC     = sliceIn[i] & rippleC;
      end
      sliceCout = rippleC;
      workUpd = work_q;
      workUpd[32'(idx_q)*NIB_W +: NIB_W] = sliceSum;
   end

   assign lastStep = (idx_q == IDX_W'(STEPS - 1));

`ifdef INC_EARLY_EXIT_EN
   // Once the carry dies out, the upper nibbles can no longer change.
   assign finish = lastStep || !sliceCout;
`else
   assign finish = lastStep;
`endif

   // Next-state and datapath update. dout/cout are written only on the way
   // into DONE, so partially processed words never reach the outputs.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               work_d  = din_i;
               carry_d = 1'b1;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d  = workUpd;
            carry_d = sliceCout;
            if (finish) begin
               dout_d  = workUpd;
               cout_d  = sliceCout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs are pure decodes of the current state.
   always_comb begin
      ready_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE:    ready_o = 1'b1;
         RUN:     busy_o  = 1'b1;
         DONE:    done_o  = 1'b1;
         default: ready_o = 1'b0;
      endcase
   end

   assign dout_o = dout_q;
   assign cout_o = cout_q;

endmodule

// File: tb/tb_inc16_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inc16_serial_ctrl
//
// Bench for the nibble-serial incrementer. The reference model tracks each
// accepted request in three parts:
//   - the arithmetic result, din + 1;
//   - the number of cycles until done, from the nibble count;
//   - a countdown of the cycles the request still occupies.
// The outputs are compared against this model on every negative edge. The
// directed tests also pin the results and done cycles with literal values.
// ---------------------------------------------------------------------------
module tb_inc16_serial_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] din;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] dout;
   logic        cout;

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   // Reference model state
   int          mRem   = 0;
   logic [15:0] mRes   = '0;
   logic        mResC  = 1'b0;
   logic [15:0] mDout  = '0;
   logic        mCout  = 1'b0;
   bit          mValid = 1'b0;

`ifdef INC_EARLY_EXIT_EN
   localparam int LAT0000 = 2;
   localparam int LAT00FF = 4;
   localparam int LATABCF = 3;
   localparam int LAT8000 = 2;
`else
   localparam int LAT0000 = 5;
   localparam int LAT00FF = 5;
   localparam int LATABCF = 5;
   localparam int LAT8000 = 5;
`endif

   always #5 clk = ~clk;

   inc16_serial_ctrl #(.DATA_W(16), .NIB_W(4)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .din_i   (din),
      .ready_o (ready),
      .busy_o  (busy),
      .done_o  (done),
      .dout_o  (dout),
      .cout_o  (cout)
   );

   // Number of cycles from the accepting edge until the done cycle. With the
   // early exit, this is one cycle per processed nibble plus one. A nibble is
   // processed for every trailing 0xF nibble, plus the nibble that absorbs
   // the carry.
   function automatic int expLatency(input logic [15:0] d);
      int          k;
      logic [15:0] v;
      v = d;
`ifdef INC_EARLY_EXIT_EN
      k = 1;
      while (k < 4 && v[3:0] == 4'hF) begin
         k++;
         v = v >> 4;
      end
`else
      k = 4;
`endif
      return k + 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model update at each rising edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         mRem   <= 0;
         mDout  <= '0;
         mCout  <= 1'b0;
         mValid <= 1'b1;
      end else if (mRem == 0) begin
         if (start) begin
            mRem  <= expLatency(din);
            mRes  <= din + 16'd1;
            mResC <= (din == 16'hFFFF);
         end
      end else begin
         mRem <= mRem - 1;
         if (mRem == 2) begin
            mDout <= mRes;
            mCout <= mResC;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("cyc.ready", 32'(ready), 32'(mRem == 0));
         checkOutput("cyc.busy",  32'(busy),  32'(mRem > 1));
         checkOutput("cyc.done",  32'(done),  32'(mRem == 1));
         checkOutput("cyc.dout",  32'(dout),  32'(mDout));
         checkOutput("cyc.cout",  32'(cout),  32'(mCout));
      end
   end

   // Raises start for one cycle with operand d. Returns in cycle 1 of the request.
   task automatic applyStimulus(input logic [15:0] d, output int startCyc);
      start    = 1'b1;
      din      = d;
      startCyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int startCyc, output int doneCyc,
                           output logic [15:0] dOut, output logic cOut);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done !== 1'b1) begin
         checkOutput("doneTimeout", 32'd0, 32'd1);
         doneCyc = -1;
      end else begin
         doneCyc = cyc - startCyc;
      end
      dOut = dout;
      cOut = cout;
   endtask

   task automatic runOne(input string name, input logic [15:0] d, input logic [15:0] expDout,
                         input logic expCout, input int expCyc);
      int          s;
      int          dc;
      logic [15:0] o;
      logic        c;
      applyStimulus(d, s);
      waitDone(s, dc, o, c);
      checkOutput({name, ".dout"}, 32'(o), 32'(expDout));
      checkOutput({name, ".cout"}, 32'(c), 32'(expCout));
      checkOutput({name, ".doneCycle"}, 32'(dc), 32'(expCyc));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          s;
      int          pulses;
      int          lastDone;
      int          readyCnt;
      int          nDone;
      logic [15:0] got;

      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Outputs right after reset
      checkOutput("rst.ready", 32'(ready), 32'd1);
      checkOutput("rst.busy",  32'(busy),  32'd0);
      checkOutput("rst.done",  32'(done),  32'd0);
      checkOutput("rst.dout",  32'(dout),  32'd0);
      checkOutput("rst.cout",  32'(cout),  32'd0);

      // Basic increments, including the wrap-around case
      runOne("T1", 16'h0000, 16'h0001, 1'b0, LAT0000);
      runOne("T2", 16'h00FF, 16'h0100, 1'b0, LAT00FF);
      runOne("T3", 16'hFFFF, 16'h0000, 1'b1, 5);
      runOne("X1", 16'hABCF, 16'hABD0, 1'b0, LATABCF);
      runOne("X2", 16'h8000, 16'h8001, 1'b0, LAT8000);

      // A second start during the request must be ignored
      applyStimulus(16'h1234, s);
      pulses = 0;
      got    = '0;
      for (int i = 1; i <= 12; i++) begin
         start = (cyc - s == 2);
         din   = (cyc - s == 2) ? 16'hAAAA : 16'h1234;
         if (done === 1'b1) begin
            pulses++;
            got = dout;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      checkOutput("T4.pulses", 32'(pulses), 32'd1);
      checkOutput("T4.dout",   32'(got),    32'h1235);

      // Reset in the middle of a request
      applyStimulus(16'h0FFF, s);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("T5.ready", 32'(ready), 32'd1);
      checkOutput("T5.busy",  32'(busy),  32'd0);
      checkOutput("T5.done",  32'(done),  32'd0);
      checkOutput("T5.dout",  32'(dout),  32'd0);
      checkOutput("T5.cout",  32'(cout),  32'd0);
      runOne("T5b", 16'h0007, 16'h0008, 1'b0, LAT0000);

      // start held high: back-to-back requests at the minimum issue period
      start    = 1'b1;
      din      = 16'h7FFF;
      lastDone = -1;
      readyCnt = 0;
      nDone    = 0;
      for (int i = 0; i < 30; i++) begin
         if (done === 1'b1) begin
            nDone++;
            checkOutput("T6.dout", 32'(dout), 32'h8000);
            checkOutput("T6.cout", 32'(cout), 32'd0);
            if (lastDone >= 0) begin
               checkOutput("T6.period",   32'(cyc - lastDone), 32'd6);
               checkOutput("T6.readyCnt", 32'(readyCnt),       32'd1);
            end
            lastDone = cyc;
            readyCnt = 0;
         end else if (ready === 1'b1) begin
            readyCnt++;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      checkOutput("T6.nDone", 32'(nDone), 32'd5);
      repeat (8) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
